// File: rtl/par_to_ser_frame.sv
// par_to_ser_frame: loads a WIDTH*WORDS-bit parallel frame and shifts it out
// one bit per ena-high cycle, then pulses latch for one cycle.
// Build option: define PAR_TO_SER_QUEUE_EN to add a one-entry holding register
// that accepts a frame written while the current one is still shifting.
module par_to_ser_frame #(
    parameter int WIDTH     = 8,
    parameter int WORDS     = 6,
    parameter int MSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   write,
    input  logic [WIDTH*WORDS-1:0] data_in,
    output logic                   data_out,
    output logic                   shift_tick,
    output logic                   latch,
    output logic                   ready,
    output logic                   busy,
    output logic                   overrun
);
    localparam int N  = WIDTH * WORDS;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t        state_reg;
    logic [N-1:0]  shift_reg;
    logic [N-1:0]  shift_next;
    logic [N-1:0]  data_ord;
    logic [CW-1:0] cnt_reg;
    logic          data_out_reg;
    logic          latch_reg;
    logic          overrun_reg;

    // Source of a frame that can start straight out of LATCH, and drop flag
    logic          queued_valid;
    logic [N-1:0]  queued_data;
    logic          write_drop;

    // Reorder the input so the transmit order always runs from bit N-1 down,
    // which lets the shifter be a plain left shift for either bit order
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_order
            if (MSB_FIRST != 0) begin : g_msb
                assign data_ord[gi] = data_in[gi];
            end else begin : g_lsb
                assign data_ord[gi] = data_in[N-1-gi];
            end
        end
    endgenerate

    assign shift_next = shift_reg << 1;
    assign busy       = (state_reg != IDLE);
    assign shift_tick = ena && (state_reg == SHIFT);
    assign data_out   = data_out_reg;
    assign latch      = latch_reg;
    assign overrun    = overrun_reg;

`ifdef PAR_TO_SER_QUEUE_EN
    logic [N-1:0] hold_reg;
    logic         hold_valid_reg;

    // Park a frame written during SHIFT; it is consumed when LATCH restarts SHIFT
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_reg <= 1'b0;
            hold_reg       <= '0;
        end else if (state_reg == LATCH && hold_valid_reg) begin
            hold_valid_reg <= 1'b0;
        end else if (state_reg == SHIFT && write && !hold_valid_reg) begin
            hold_valid_reg <= 1'b1;
            hold_reg       <= data_ord;
        end
    end

    // A write in LATCH with an empty holder goes straight into the shifter
    assign ready        = ~hold_valid_reg;
    assign write_drop   = write & busy & hold_valid_reg;
    assign queued_valid = hold_valid_reg | write;
    assign queued_data  = hold_valid_reg ? hold_reg : data_ord;
`else
    assign ready        = ~busy;
    assign write_drop   = write & busy;
    assign queued_valid = 1'b0;
    assign queued_data  = '0;
`endif

    // Frame sequencer: load, shift on ena, one LATCH cycle, optional chaining
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            cnt_reg      <= '0;
            data_out_reg <= 1'b0;
            latch_reg    <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            latch_reg   <= 1'b0;
            overrun_reg <= write_drop;
            case (state_reg)
                IDLE: begin
                    if (write) begin
                        shift_reg    <= data_ord;
                        cnt_reg      <= '0;
                        data_out_reg <= data_ord[N-1];
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ena) begin
                        cnt_reg <= cnt_reg + CW'(1);
                        if (cnt_reg == LAST_IDX) begin
                            // Last bit leaves on this edge; line goes quiet in LATCH
                            state_reg    <= LATCH;
                            latch_reg    <= 1'b1;
                            data_out_reg <= 1'b0;
                            shift_reg    <= '0;
                        end else begin
                            shift_reg    <= shift_next;
                            data_out_reg <= shift_next[N-1];
                        end
                    end
                end
                LATCH: begin
                    if (queued_valid) begin
                        shift_reg    <= queued_data;
                        cnt_reg      <= '0;
                        data_out_reg <= queued_data[N-1];
                        state_reg    <= SHIFT;
                    end else begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    data_out_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_par_to_ser_frame.sv
// tb_par_to_ser_frame: scoreboard bench; expected serial bits are queued when a
// frame is written and popped on every shift_tick. Two instances cover
// 8x1 MSB-first and 8x2 LSB-first framing.
`timescale 1ns/1ps
module tb_par_to_ser_frame;
`ifdef PAR_TO_SER_QUEUE_EN
    localparam bit QMODE = 1'b1;
`else
    localparam bit QMODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        write_a = 1'b0;
    logic        write_b = 1'b0;
    logic [7:0]  din_a = '0;
    logic [15:0] din_b = '0;
    logic        dout_a, tick_a, latch_a, ready_a, busy_a, ovr_a;
    logic        dout_b, tick_b, latch_b, ready_b, busy_b, ovr_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic b;
        logic last;
    } sb_t;

    sb_t  exp_a[$];
    sb_t  exp_b[$];
    logic due_a = 1'b0;
    logic due_b = 1'b0;
    int   latches_a = 0;
    int   latches_b = 0;

    par_to_ser_frame #(.WIDTH(8), .WORDS(1), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .write(write_a), .data_in(din_a),
        .data_out(dout_a), .shift_tick(tick_a), .latch(latch_a),
        .ready(ready_a), .busy(busy_a), .overrun(ovr_a)
    );

    par_to_ser_frame #(.WIDTH(8), .WORDS(2), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .write(write_b), .data_in(din_b),
        .data_out(dout_b), .shift_tick(tick_b), .latch(latch_b),
        .ready(ready_b), .busy(busy_b), .overrun(ovr_b)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame_a(input logic [7:0] v);
        sb_t e;
        for (int i = 0; i < 8; i++) begin
            e.b    = v[7-i];
            e.last = (i == 7);
            exp_a.push_back(e);
        end
    endtask

    task automatic push_frame_b(input logic [15:0] v);
        sb_t e;
        for (int i = 0; i < 16; i++) begin
            e.b    = v[i];
            e.last = (i == 15);
            exp_b.push_back(e);
        end
    endtask

    // Monitor A: latch must follow the last bit by exactly one cycle
    initial forever begin
        sb_t e;
        @(negedge clk);
        if (rst) begin
            due_a = 1'b0;
        end else begin
            check("latch_a", 32'(latch_a), 32'(due_a));
            if (latch_a) latches_a++;
            due_a = 1'b0;
            if (tick_a) begin
                if (exp_a.size() == 0) begin
                    check("tick_a_unexpected", 32'(tick_a), 32'(0));
                end else begin
                    e = exp_a.pop_front();
                    check("bit_a", 32'(dout_a), 32'(e.b));
                    due_a = e.last;
                end
            end
        end
    end

    // Monitor B
    initial forever begin
        sb_t e;
        @(negedge clk);
        if (rst) begin
            due_b = 1'b0;
        end else begin
            check("latch_b", 32'(latch_b), 32'(due_b));
            if (latch_b) latches_b++;
            due_b = 1'b0;
            if (tick_b) begin
                if (exp_b.size() == 0) begin
                    check("tick_b_unexpected", 32'(tick_b), 32'(0));
                end else begin
                    e = exp_b.pop_front();
                    check("bit_b", 32'(dout_b), 32'(e.b));
                    due_b = e.last;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns cycles from write-drive time w to the latch negedge, -1 on timeout
    task automatic wait_latch_a(input int w, output int lat);
        lat = -1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (latch_a) begin
                lat = cyc - w;
                break;
            end
        end
        if (lat < 0) check("latch_a_timeout", 32'(latch_a), 32'(1));
        $display("frame A done: latency %0d", lat);
    endtask

    task automatic wait_latch_b(input int w, output int lat);
        lat = -1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (latch_b) begin
                lat = cyc - w;
                break;
            end
        end
        if (lat < 0) check("latch_b_timeout", 32'(latch_b), 32'(1));
        $display("frame B done: latency %0d", lat);
    endtask

    initial begin
        int w;
        int lat;
        logic [7:0] rv;

        // Reset, including a write coincident with reset that must be ignored
        repeat (3) step();
        write_a = 1'b1;
        din_a   = 8'hFF;
        step();
        write_a = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        check("rst_dout_a", 32'(dout_a), 32'(0));
        check("rst_latch_a", 32'(latch_a), 32'(0));
        check("rst_busy_a", 32'(busy_a), 32'(0));
        check("rst_ready_a", 32'(ready_a), 32'(1));
        check("rst_ovr_a", 32'(ovr_a), 32'(0));
        check("rst_busy_b", 32'(busy_b), 32'(0));
        check("rst_ready_b", 32'(ready_b), 32'(1));
        check("rst_dout_b", 32'(dout_b), 32'(0));

        // Plain A5 frame with ena held high
        step();
        ena     = 1'b1;
        din_a   = 8'hA5;
        write_a = 1'b1;
        push_frame_a(8'hA5);
        w = cyc;
        step();
        write_a = 1'b0;
        @(negedge clk);
        check("a5_busy", 32'(busy_a), 32'(1));
        check("a5_ready", 32'(ready_a), 32'(QMODE));
        check("a5_first_bit", 32'(dout_a), 32'(1));
        wait_latch_a(w, lat);
        check("a5_latency", 32'(lat), 32'(9));
        check("a5_dout_latch", 32'(dout_a), 32'(0));
        @(negedge clk);
        check("a5_ready_after", 32'(ready_a), 32'(1));
        check("a5_busy_after", 32'(busy_a), 32'(0));
        check("a5_sb_empty", 32'(exp_a.size()), 32'(0));

        // Same frame with ena low for three cycles after three bits
        step();
        din_a   = 8'hA5;
        write_a = 1'b1;
        push_frame_a(8'hA5);
        w = cyc;
        step();
        write_a = 1'b0;
        repeat (3) step();
        check("frz_pos", 32'(exp_a.size()), 32'(5));
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("frz_tick", 32'(tick_a), 32'(0));
            check("frz_dout", 32'(dout_a), 32'(exp_a[0].b));
            check("frz_busy", 32'(busy_a), 32'(1));
            step();
        end
        ena = 1'b1;
        wait_latch_a(w, lat);
        check("frz_latency", 32'(lat), 32'(12));

        // Reset after three bits, then a full 81 frame
        step();
        din_a   = 8'hA5;
        write_a = 1'b1;
        push_frame_a(8'hA5);
        step();
        write_a = 1'b0;
        step();
        step();
        @(negedge clk);
        step();
        rst = 1'b1;
        ena = 1'b0;
        step();
        rst = 1'b0;
        ena = 1'b1;
        exp_a.delete();
        @(negedge clk);
        check("mrst_dout", 32'(dout_a), 32'(0));
        check("mrst_busy", 32'(busy_a), 32'(0));
        check("mrst_ready", 32'(ready_a), 32'(1));
        repeat (3) step();
        din_a   = 8'h81;
        write_a = 1'b1;
        push_frame_a(8'h81);
        w = cyc;
        step();
        write_a = 1'b0;
        wait_latch_a(w, lat);
        check("mrst_81_latency", 32'(lat), 32'(9));

        // Back-to-back writes A5 then 81
        step();
        lat = latches_a;
        w = cyc;
        din_a   = 8'hA5;
        write_a = 1'b1;
        push_frame_a(8'hA5);
        step();
        din_a = 8'h81;
        if (QMODE) push_frame_a(8'h81);
        @(negedge clk);
        check("b2b_ovr_n1", 32'(ovr_a), 32'(0));
        step();
        write_a = 1'b0;
        @(negedge clk);
        check("b2b_ovr_n2", 32'(ovr_a), 32'(!QMODE));
        check("b2b_ready_n2", 32'(ready_a), 32'(0));
        step();
        @(negedge clk);
        check("b2b_ovr_n3", 32'(ovr_a), 32'(0));
        wait_latch_a(w, lat);
        check("b2b_lat1", 32'(lat), 32'(9));
        if (QMODE) begin
            @(negedge clk);
            check("b2b_chain_busy", 32'(busy_a), 32'(1));
            wait_latch_a(w, lat);
            check("b2b_lat2", 32'(lat), 32'(18));
        end else begin
            repeat (12) step();
            check("b2b_idle_busy", 32'(busy_a), 32'(0));
        end
        check("b2b_sb_empty", 32'(exp_a.size()), 32'(0));

        // Random frames with random ena gaps
        for (int f = 0; f < 4; f++) begin
            step();
            ena     = 1'b1;
            rv      = 8'($urandom);
            din_a   = rv;
            write_a = 1'b1;
            push_frame_a(rv);
            step();
            write_a = 1'b0;
            lat = -1;
            for (int k = 0; k < 200; k++) begin
                ena = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (latch_a) begin
                    lat = k;
                    break;
                end
                step();
            end
            if (lat < 0) check("rnd_latch_timeout", 32'(latch_a), 32'(1));
            $display("frame A random %0h done", rv);
        end
        ena = 1'b1;

        // 8x2 LSB-first, 8001 written with ena low (ena ignored in IDLE)
        step();
        ena     = 1'b0;
        din_b   = 16'h8001;
        write_b = 1'b1;
        push_frame_b(16'h8001);
        w = cyc;
        step();
        write_b = 1'b0;
        @(negedge clk);
        check("b_busy_ena0", 32'(busy_b), 32'(1));
        check("b_first_bit", 32'(dout_b), 32'(1));
        step();
        ena = 1'b1;
        wait_latch_b(w, lat);
        check("b_8001_latency", 32'(lat), 32'(18));

        step();
        din_b   = 16'h3C5A;
        write_b = 1'b1;
        push_frame_b(16'h3C5A);
        w = cyc;
        step();
        write_b = 1'b0;
        wait_latch_b(w, lat);
        check("b_3c5a_latency", 32'(lat), 32'(17));
        @(negedge clk);
        check("b_ready_after", 32'(ready_b), 32'(1));
        check("b_sb_empty", 32'(exp_b.size()), 32'(0));
        check("a_sb_final", 32'(exp_a.size()), 32'(0));

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/par_to_ser_frame.md
PAR_TO_SER_FRAME -- requirements
Module: par_to_ser_frame

Interface
- REQ-001: Parameter WIDTH, default 8, bits per word; legal range 1..32.
- REQ-002: Parameter WORDS, default 6, words per frame; legal range 1..8.
- REQ-003: Parameter MSB_FIRST, default 1; 1 = frame MSB first, 0 = frame LSB first.
- REQ-004: One clock; reset is synchronous and active-high.
- REQ-005: clk  input  1  sole clock; all state changes on rising edge.
- REQ-006: rst  input  1  synchronous active-high reset.
- REQ-007: ena  input  1  shift-rate tick; one bit advances per ena-high cycle in SHIFT.
- REQ-008: write  input  1  load strobe, sampled every cycle.
- REQ-009: data_in  input  WIDTH*WORDS  parallel frame; word 0 in the low WIDTH bits.
- REQ-010: data_out  output  1  serial bit, registered.
- REQ-011: shift_tick  output  1  combinational; equals ena AND state==SHIFT; downstream samples data_out on this cycle's edge.
- REQ-012: latch  output  1  registered one-cycle pulse after the last bit of a frame.
- REQ-013: ready  output  1  high when a write will be accepted without loss.
- REQ-014: busy  output  1  high in SHIFT or LATCH.
- REQ-015: overrun  output  1  registered one-cycle pulse when a write is dropped.

Function
- REQ-016: The FSM SHALL have exactly three states: IDLE, SHIFT and LATCH.
- REQ-017: IDLE with write=1 SHALL load data_in into the shift register, clear the bit counter and enter SHIFT next cycle; ena is ignored in IDLE.
- REQ-018: In the first SHIFT cycle, data_out SHALL equal data_in[N-1] (MSB_FIRST=1) or data_in[0] (MSB_FIRST=0), where N=WIDTH*WORDS.
- REQ-019: In SHIFT, each cycle with ena=1 SHALL present the next bit and increment the counter; ena=0 SHALL freeze data_out, the counter and the state.
- REQ-020: The ena-high cycle that shifts bit N SHALL move the FSM to LATCH; latch=1 for exactly that one LATCH cycle, independent of ena.
- REQ-021: LATCH SHALL return to IDLE next cycle unless a queued frame exists (REQ-031).
- REQ-022: data_out SHALL be 0 in IDLE and LATCH.
- REQ-023: A write while busy SHALL be handled per Configuration; the active frame is never corrupted.
- REQ-024: The bit counter SHALL be $clog2(N+1) bits wide and SHALL never exceed N.
- REQ-025: The write-to-first-shift latency SHALL be 1 cycle, and the last-shift-to-latch latency SHALL be 1 cycle.
- REQ-026: A write in the same cycle as rst SHALL be ignored.

Reset
- REQ-027: On rst=1 at a clock edge, the block SHALL enter IDLE from any state, mid-frame included, and discard the shift register, counter and any queued frame.
- REQ-028: Reset values SHALL be: data_out=0, latch=0, busy=0, ready=1, overrun=0.

Configuration
- REQ-029: The macro PAR_TO_SER_QUEUE_EN SHALL compile in a one-entry holding register.
- REQ-030: Without the macro, ready SHALL equal NOT busy, and any write while busy SHALL be dropped with overrun pulsed on the next cycle.
- REQ-031: With the macro, a write while busy and the holding register empty SHALL be captured; ready SHALL equal holding-empty; LATCH then SHALL go directly to SHIFT with the held frame (no IDLE cycle); a write while holding full SHALL be dropped with overrun pulsed.

Verification
- REQ-032: WIDTH=8, WORDS=1, MSB_FIRST=1, ena=1, write 8'hA5 -> data_out 1,0,1,0,0,1,0,1 on 8 consecutive shift_tick cycles, latch high on the cycle after, ready high on the cycle after that.
- REQ-033: Same load with ena low for 3 cycles mid-frame -> data_out and counter hold, frame completes 3 cycles late, bit sequence unchanged.
- REQ-034: MSB_FIRST=0, WORDS=2, data_in 16'h8001 -> first bit 1, then 14 zeros, then 1, then a latch pulse.
- REQ-035: rst asserted after 3 bits of 8'hA5 -> next cycle IDLE, data_out=0, busy=0, no latch pulse; a following write of 8'h81 gives the full 8-bit sequence.
- REQ-036: Two back-to-back writes, 8'hA5 then 8'h81 -> without PAR_TO_SER_QUEUE_EN, 8'h81 is dropped and overrun pulses once; with it, 8'h81 shifts immediately after the 8'hA5 latch cycle, giving two latch pulses.
